// File: rtl/video_timing_gen.sv
// video_timing_gen: 15 kHz arcade raster timing (pixel enable, beam counters, blanking, syncs)
// with blanked, sync-aligned colour output. Define VTG_TESTPATTERN_EN for the colour-bar source.
module video_timing_gen #(
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 16,
    parameter int V_SYNC   = 8,
    parameter int V_BP     = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       test_en,
    output logic       pix_ce,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HSync,
    output logic       VSync,
    output logic       HBlank,
    output logic       VBlank,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

    localparam logic [CW-1:0] CDIV_LAST = CW'(CE_DIV - 1);
    localparam logic [8:0]    H_LAST    = 9'(H_TOTAL - 1);
    localparam logic [8:0]    V_LAST    = 9'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_BEG    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_BEG    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 512");
    end
    if (CE_DIV < 2) begin : g_bad_div
        $error("video_timing_gen: CE_DIV must be at least 2");
    end

    logic [CW-1:0] r_cdiv;
    logic [8:0]    r_hcount, r_vcount;
    logic          r_frame_start;
    logic          r_hblank_d, r_vblank_d, r_hs_d, r_vs_d;
    logic          r_hblank, r_vblank, r_hs, r_vs;
    logic [7:0]    r_r, r_g, r_b;
    logic          w_pix_ce, w_h_last, w_v_last;
    logic          w_hblank_c, w_vblank_c, w_hs_c, w_vs_c;
    logic [7:0]    w_src_r, w_src_g, w_src_b;

    assign w_pix_ce   = (r_cdiv == CDIV_LAST);
    assign w_h_last   = (r_hcount == H_LAST);
    assign w_v_last   = (r_vcount == V_LAST);

    assign w_hblank_c = ({1'b0, r_hcount} >= H_ACT);
    assign w_vblank_c = ({1'b0, r_vcount} >= V_ACT);
    assign w_hs_c     = ({1'b0, r_hcount} >= HS_BEG) && ({1'b0, r_hcount} <= HS_END);
    assign w_vs_c     = ({1'b0, r_vcount} >= VS_BEG) && ({1'b0, r_vcount} <= VS_END);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cdiv        <= '0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cdiv        <= w_pix_ce ? '0 : r_cdiv + CW'(1);
            r_frame_start <= 1'b0;
            if (w_pix_ce) begin
                if (w_h_last) begin
                    r_hcount <= '0;
                    if (w_v_last) begin
                        r_vcount      <= '0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_vcount <= r_vcount + 9'd1;
                    end
                end else begin
                    r_hcount <= r_hcount + 9'd1;
                end
            end
        end
    end

    // The core answers one pixel after seeing the counters, so flags pass through one extra stage.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            {r_hblank_d, r_vblank_d, r_hs_d, r_vs_d} <= '0;
            {r_hblank, r_vblank, r_hs, r_vs}         <= '0;
            {r_r, r_g, r_b}                          <= '0;
        end else if (w_pix_ce) begin
            r_hblank_d <= w_hblank_c;
            r_vblank_d <= w_vblank_c;
            r_hs_d     <= w_hs_c;
            r_vs_d     <= w_vs_c;
            r_hblank   <= r_hblank_d;
            r_vblank   <= r_vblank_d;
            r_hs       <= r_hs_d;
            r_vs       <= r_vs_d;
            if (r_hblank_d || r_vblank_d) begin
                {r_r, r_g, r_b} <= '0;
            end else begin
                {r_r, r_g, r_b} <= {w_src_r, w_src_g, w_src_b};
            end
        end
    end

`ifdef VTG_TESTPATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [BW-1:0] r_bar_cnt;
    logic [3:0]    r_bar_idx;
    logic [2:0]    r_bar_d;
    logic [2:0]    w_bar_rgb;

    // Bar position tracks the current hcount; its colour is delayed to line up with the core's answer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_bar_d   <= '0;
        end else if (w_pix_ce) begin
            r_bar_d <= w_bar_rgb;
            if (w_h_last) begin
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_idx != 4'd8) begin
                if (r_bar_cnt == BAR_LAST) begin
                    r_bar_cnt <= '0;
                    r_bar_idx <= r_bar_idx + 4'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + BW'(1);
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_bar_rgb = 3'b000;
        case (r_bar_idx)
            4'd0: w_bar_rgb = 3'b111;
            4'd1: w_bar_rgb = 3'b110;
            4'd2: w_bar_rgb = 3'b011;
            4'd3: w_bar_rgb = 3'b010;
            4'd4: w_bar_rgb = 3'b101;
            4'd5: w_bar_rgb = 3'b100;
            4'd6: w_bar_rgb = 3'b001;
            default: w_bar_rgb = 3'b000;
        endcase
    end

    always_comb begin
        w_src_r = r_in;
        w_src_g = g_in;
        w_src_b = b_in;
        if (test_en) begin
            w_src_r = {8{r_bar_d[2]}};
            w_src_g = {8{r_bar_d[1]}};
            w_src_b = {8{r_bar_d[0]}};
        end
    end
`else
    logic w_unused_test_en;
    assign w_unused_test_en = test_en;
    assign w_src_r = r_in;
    assign w_src_g = g_in;
    assign w_src_b = b_in;
`endif

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign pix_ce      = w_pix_ce;
    assign R           = r_r;
    assign G           = r_g;
    assign B           = r_b;
    assign HSync       = r_hs;
    assign VSync       = r_vs;
    assign HBlank      = r_hblank;
    assign VBlank      = r_vblank;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced raster, compared against a
// pixel-index reference model; a registered core model supplies colour one pixel late.
module tb_video_timing_gen;
    localparam int CE_DIV = 3;
    localparam int HA = 36, HFP = 4, HSW = 6, HBP = 10;
    localparam int VA = 20, VFP = 3, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int BAR_W = HA / 8;
`ifdef VTG_TESTPATTERN_EN
    localparam bit TP_BUILD = 1'b1;
`else
    localparam bit TP_BUILD = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] hcount, vcount;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic       test_en = 1'b0;
    logic       pix_ce;
    logic [7:0] R, G, B;
    logic       HSync, VSync, HBlank, VBlank, frame_start;

    video_timing_gen #(
        .CE_DIV(CE_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .hcount(hcount), .vcount(vcount),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .test_en(test_en), .pix_ce(pix_ce),
        .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync), .HBlank(HBlank),
        .VBlank(VBlank), .frame_start(frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    int          cur_p = 0;
    bit          abort = 1'b0;
    bit          ff_blank = 1'b0;
    logic [7:0]  key_r = '0, key_g = '0, key_b = '0;
    logic [23:0] pend = '0;
    logic [27:0] last_out = '0;
    logic [2:0]  bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    function automatic logic [23:0] core_rgb(int h, int v);
        logic [7:0] hh, vv, sv;
        if (ff_blank && (h >= HA || v >= VA)) return 24'hFFFFFF;
        hh = 8'(h);
        vv = 8'(v);
        sv = 8'(h + v);
        return {hh ^ key_r, vv ^ key_g, sv ^ key_b};
    endfunction

    function automatic logic [23:0] bar_rgb(int h);
        logic [2:0] c;
        if (h / BAR_W >= 8) return 24'h0;
        c = bar_tab[h / BAR_W];
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    // Core stand-in: registers the colour for the requested pixel on each pixel enable.
    always @(negedge clk_sys) begin
        if (reset) begin
            pend = '0;
            {r_in, g_in, b_in} = '0;
        end else if (pix_ce) begin
            {r_in, g_in, b_in} = pend;
            pend = core_rgb(int'(hcount), int'(vcount));
        end
    end

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk_sys);
            #1;
            checks++;
            if ({hcount, vcount, pix_ce, R, G, B, HSync, VSync, HBlank, VBlank, frame_start} !== '0) begin
                failures++;
                $display("FAIL reset_state cycle %0d: got h=%0d v=%0d ce=%b rgb=%02h%02h%02h hs=%b vs=%b hb=%b vb=%b fs=%b, want all 0",
                         i, hcount, vcount, pix_ce, R, G, B, HSync, VSync, HBlank, VBlank, frame_start);
            end
        end
        reset = 1'b0;
        k = 0;
        last_out = '0;
    endtask

    task automatic step_pix();
        int n, h, v;
        bit got, hb, vb, hs, vs, exp_fs;
        logic [3:0]  exp_flags;
        logic [23:0] exp_rgb;
        if (abort) return;
        got = 1'b0;
        n = 0;
        for (int i = 1; i <= CE_DIV + 2; i++) begin
            @(negedge clk_sys);
            if (pix_ce === 1'b1) begin
                got = 1'b1;
                n = i;
                break;
            end
            checks++;
            if ({R, G, B, HSync, VSync, HBlank, VBlank} !== last_out) begin
                failures++;
                $display("FAIL hold k=%0d: got %07h, want %07h", k, {R, G, B, HSync, VSync, HBlank, VBlank}, last_out);
            end
            if (i >= 2) begin
                checks++;
                if (frame_start !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_start_width k=%0d: got %b, want 0", k, frame_start);
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL pix_ce_timeout k=%0d: got no pix_ce in %0d clocks, want one", k, CE_DIV + 2);
            abort = 1'b1;
            return;
        end
        if (n != CE_DIV) begin
            failures++;
            $display("FAIL pix_ce_period k=%0d: got %0d clocks, want %0d", k, n, CE_DIV);
        end
        @(posedge clk_sys);
        #1;
        k++;
        checks++;
        if ({hcount, vcount} !== {9'(k % HT), 9'((k / HT) % VT)}) begin
            failures++;
            $display("FAIL counters k=%0d: got (%0d,%0d), want (%0d,%0d)", k, hcount, vcount, k % HT, (k / HT) % VT);
        end
        exp_fs = (k % FT == 0);
        checks++;
        if (frame_start !== exp_fs) begin
            failures++;
            $display("FAIL frame_start k=%0d: got %b, want %b", k, frame_start, exp_fs);
        end
        if (k == 1) begin
            exp_flags = '0;
            exp_rgb = '0;
            cur_p = -1;
        end else begin
            cur_p = k - 2;
            h = cur_p % HT;
            v = (cur_p / HT) % VT;
            hb = (h >= HA);
            vb = (v >= VA);
            hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
            vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
            exp_flags = {hs, vs, hb, vb};
            if (hb || vb) exp_rgb = '0;
            else if (TP_BUILD && test_en) exp_rgb = bar_rgb(h);
            else exp_rgb = core_rgb(h, v);
        end
        checks++;
        if ({HSync, VSync, HBlank, VBlank} !== exp_flags) begin
            failures++;
            $display("FAIL sync_blank pixel %0d: got hs/vs/hb/vb=%b, want %b", cur_p, {HSync, VSync, HBlank, VBlank}, exp_flags);
        end
        checks++;
        if ({R, G, B} !== exp_rgb) begin
            failures++;
            $display("FAIL rgb pixel %0d: got %06h, want %06h", cur_p, {R, G, B}, exp_rgb);
        end
        last_out = {R, G, B, HSync, VSync, HBlank, VBlank};
    endtask

    task automatic random_keys();
        key_r = 8'($urandom);
        key_g = 8'($urandom);
        key_b = 8'($urandom);
        ff_blank = 1'b0;
    endtask

    task automatic test_reset();
        random_keys();
        test_en = 1'b0;
        do_reset(3);
        repeat (4) step_pix();
    endtask

    task automatic test_line();
        int hs_cnt, first_p, c_l0, c_l1;
        random_keys();
        test_en = 1'($urandom);
        do_reset(2);
        hs_cnt = 0;
        first_p = -1;
        c_l0 = 0;
        c_l1 = 0;
        repeat (2 * HT + 2) begin
            step_pix();
            if (cur_p >= 0 && cur_p < HT && HSync === 1'b1) begin
                hs_cnt++;
                if (first_p < 0) first_p = cur_p;
            end
            if (cur_p == HA + HFP) c_l0 = cyc;
            if (cur_p == HT + HA + HFP) c_l1 = cyc;
        end
        checks++;
        if (hs_cnt != HSW) begin
            failures++;
            $display("FAIL hsync_width: got %0d pixels, want %0d", hs_cnt, HSW);
        end
        checks++;
        if (first_p != HA + HFP) begin
            failures++;
            $display("FAIL hsync_start: got pixel %0d, want %0d", first_p, HA + HFP);
        end
        checks++;
        if (c_l1 - c_l0 != HT * CE_DIV) begin
            failures++;
            $display("FAIL line_period: got %0d clocks, want %0d", c_l1 - c_l0, HT * CE_DIV);
        end
    endtask

    task automatic test_frames();
        int vs_cnt, vb_cnt, vs_first, fs_cnt, fs_c0, fs_c1;
        random_keys();
        test_en = 1'b0;
        do_reset(2);
        vs_cnt = 0;
        vb_cnt = 0;
        vs_first = -1;
        fs_cnt = 0;
        fs_c0 = 0;
        fs_c1 = 0;
        repeat (2 * FT + 3) begin
            step_pix();
            if (cur_p >= 0 && cur_p < 2 * FT && VSync === 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = cur_p;
            end
            if (cur_p >= 0 && cur_p < FT && VBlank === 1'b1) vb_cnt++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_c0 = cyc;
                if (fs_cnt == 2) fs_c1 = cyc;
            end
        end
        checks++;
        if (vs_cnt != 2 * VSW * HT) begin
            failures++;
            $display("FAIL vsync_length: got %0d pixels, want %0d", vs_cnt, 2 * VSW * HT);
        end
        checks++;
        if (vs_first != (VA + VFP) * HT) begin
            failures++;
            $display("FAIL vsync_start: got pixel %0d, want %0d", vs_first, (VA + VFP) * HT);
        end
        checks++;
        if (vb_cnt != (VT - VA) * HT) begin
            failures++;
            $display("FAIL vblank_length: got %0d pixels, want %0d", vb_cnt, (VT - VA) * HT);
        end
        checks++;
        if (fs_cnt != 2 || fs_c1 - fs_c0 != FT * CE_DIV) begin
            failures++;
            $display("FAIL frame_period: got %0d pulses %0d clocks apart, want 2 pulses %0d apart",
                     fs_cnt, fs_c1 - fs_c0, FT * CE_DIV);
        end
    endtask

    task automatic test_blank_ff();
        key_r = 8'h00;
        key_g = 8'($urandom);
        key_b = 8'($urandom);
        ff_blank = 1'b1;
        test_en = 1'b0;
        do_reset(1);
        repeat (FT + 2) begin
            step_pix();
            if (!TP_BUILD && cur_p >= 0 && (cur_p % HT) < HA && ((cur_p / HT) % VT) < VA) begin
                checks++;
                if (R !== 8'(cur_p % HT)) begin
                    failures++;
                    $display("FAIL r_equals_x pixel %0d: got %0d, want %0d", cur_p, R, cur_p % HT);
                end
            end
        end
        ff_blank = 1'b0;
    endtask

    task automatic test_mid_reset();
        random_keys();
        test_en = 1'b0;
        do_reset(1);
        repeat (10 * HT + 20) step_pix();
        checks++;
        if (hcount !== 9'd20 || vcount !== 9'd10) begin
            failures++;
            $display("FAIL mid_reset_position: got (%0d,%0d), want (20,10)", hcount, vcount);
        end
        do_reset(1);
        repeat (HT + 4) step_pix();
    endtask

    task automatic test_test_pattern();
        random_keys();
        test_en = 1'b1;
        do_reset(1);
        repeat (2 * HT + 2) step_pix();
        test_en = 1'b0;
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_blank_ff();
        test_mid_reset();
        test_test_pattern();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
